// File: rtl/addr_seq_ctrl.sv
// Address sequencer: maps a region index to a base address and streams one 14-bit
// address per valid/ready handshake for the commanded word count.
module addr_seq_ctrl #(
    parameter int unsigned STRIDE = 1,
    parameter int unsigned LEN_W  = 13
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [3:0]       cmd_index_i,
    input  logic [LEN_W-1:0] cmd_len_i,
    input  logic             abort_i,
    output logic [13:0]      addr_o,
    output logic             addr_valid_o,
    input  logic             addr_ready_i,
    output logic             addr_last_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             aborted_o
);

    localparam logic [13:0] StrideW = 14'(STRIDE);

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

    state_e             state_q, state_d;
    logic [13:0]        addr_q, addr_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic               abort_q, abort_d;
    logic [13:0]        base;
    logic               cmd_accept, beat, last_beat;

    assign cmd_accept = (state_q == StIdle) && cmd_valid_i;
    assign beat       = (state_q == StRun) && addr_ready_i;
    assign last_beat  = beat && (rem_q == LEN_W'(1));
    assign base       = (cmd_index_i < 4'd4) ? {cmd_index_i[1:0], 12'h000}
                                             : {10'd0, cmd_index_i};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid_i) begin
                    state_d = (cmd_len_i == '0) ? StFin : StRun;
                end
            end
            StRun: begin
                if (last_beat || abort_i) begin
                    state_d = StFin;
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // A beat that completes the burst wins over a simultaneous abort.
    always_comb begin
        addr_d  = addr_q;
        rem_d   = rem_q;
        abort_d = abort_q;
        if (cmd_accept) begin
            addr_d  = base;
            rem_d   = cmd_len_i;
            abort_d = 1'b0;
        end else if (state_q == StRun) begin
            if (beat) begin
                addr_d = addr_q + StrideW;
                rem_d  = rem_q - LEN_W'(1);
            end
            abort_d = abort_i && !last_beat;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q  <= '0;
            rem_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            abort_q <= abort_d;
        end
    end

    always_comb begin
        cmd_ready_o  = 1'b0;
        addr_valid_o = 1'b0;
        addr_last_o  = 1'b0;
        busy_o       = 1'b1;
        done_o       = 1'b0;
        aborted_o    = 1'b0;
        unique case (state_q)
            StIdle: begin
                cmd_ready_o = 1'b1;
                busy_o      = 1'b0;
            end
            StRun: begin
                addr_valid_o = 1'b1;
                addr_last_o  = (rem_q == LEN_W'(1));
            end
            StFin: begin
                done_o    = !abort_q;
                aborted_o = abort_q;
            end
            default: busy_o = 1'b1;
        endcase
    end

    assign addr_o = addr_q;

endmodule

// File: tb/tb_addr_seq_ctrl.sv
// Directed bench for addr_seq_ctrl: a STRIDE=1 and a STRIDE=2 instance share stimulus.
module tb_addr_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic [3:0]  cmd_index;
    logic [12:0] cmd_len;
    logic        abort;
    logic        addr_ready;

    logic        rdy1, av1, al1, busy1, done1, ab1;
    logic [13:0] addr1;
    logic        rdy2, av2, al2, busy2, done2, ab2;
    logic [13:0] addr2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    addr_seq_ctrl #(.STRIDE(1), .LEN_W(13)) u_dut1 (
        .clk_i        (clk),
        .rst_i        (rst),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (rdy1),
        .cmd_index_i  (cmd_index),
        .cmd_len_i    (cmd_len),
        .abort_i      (abort),
        .addr_o       (addr1),
        .addr_valid_o (av1),
        .addr_ready_i (addr_ready),
        .addr_last_o  (al1),
        .busy_o       (busy1),
        .done_o       (done1),
        .aborted_o    (ab1)
    );

    addr_seq_ctrl #(.STRIDE(2), .LEN_W(13)) u_dut2 (
        .clk_i        (clk),
        .rst_i        (rst),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (rdy2),
        .cmd_index_i  (cmd_index),
        .cmd_len_i    (cmd_len),
        .abort_i      (abort),
        .addr_o       (addr2),
        .addr_valid_o (av2),
        .addr_ready_i (addr_ready),
        .addr_last_o  (al2),
        .busy_o       (busy2),
        .done_o       (done2),
        .aborted_o    (ab2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Presents a command for one cycle; returns in the first cycle after accept.
    task automatic issue(input logic [3:0] idx, input logic [12:0] len);
        cmd_valid = 1'b1;
        cmd_index = idx;
        cmd_len   = len;
        chk("cmd_ready_before_accept", {15'd0, rdy1}, 16'd1);
        step();
        cmd_valid = 1'b0;
    endtask

    logic [13:0] ex;
    int          rem;
    bit          pat [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_index = '0; cmd_len = '0;
        abort = 1'b0; addr_ready = 1'b0;
        step();
        step();
        chk("rst_cmd_ready", {15'd0, rdy1}, 16'd1);
        chk("rst_addr", {2'd0, addr1}, 16'h0000);
        chk("rst_valid", {15'd0, av1}, 16'd0);
        chk("rst_busy", {15'd0, busy1}, 16'd0);
        chk("rst_done", {15'd0, done1}, 16'd0);
        chk("rst_aborted", {15'd0, ab1}, 16'd0);
        rst = 1'b0;
        step();

        // Burst with ready tied high.
        addr_ready = 1'b1;
        issue(4'd2, 13'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t1_valid", {15'd0, av1}, 16'd1);
            chk("t1_addr", {2'd0, addr1}, 16'h2000 + 16'(i));
            chk("t1_last", {15'd0, al1}, {15'd0, i == 3});
            chk("t1_done_low", {15'd0, done1}, 16'd0);
            step();
        end
        chk("t1_done", {15'd0, done1}, 16'd1);
        chk("t1_fin_valid", {15'd0, av1}, 16'd0);
        chk("t1_fin_busy", {15'd0, busy1}, 16'd1);
        step();
        chk("t1_idle_busy", {15'd0, busy1}, 16'd0);
        chk("t1_idle_done", {15'd0, done1}, 16'd0);

        // Backpressure: address held through stalls.
        issue(4'd7, 13'd3);
        ex  = 14'h0007;
        rem = 3;
        for (int i = 0; i < 7; i++) begin
            addr_ready = pat[i];
            chk("t2_valid", {15'd0, av1}, 16'd1);
            chk("t2_addr", {2'd0, addr1}, {2'd0, ex});
            chk("t2_last", {15'd0, al1}, {15'd0, rem == 1});
            step();
            if (pat[i]) begin
                ex  = ex + 14'd1;
                rem = rem - 1;
            end
        end
        chk("t2_done", {15'd0, done1}, 16'd1);
        chk("t2_fin_valid", {15'd0, av1}, 16'd0);
        step();

        // STRIDE=2 instance wraps past 0x3FFE to 0x0000 on the last beat.
        addr_ready = 1'b1;
        issue(4'd3, 13'd2049);
        for (int i = 0; i < 2049; i++) begin
            chk("t3_addr", {2'd0, addr2}, {2'd0, 14'(16'h3000 + 16'(2 * i))});
            chk("t3_last", {15'd0, al2}, {15'd0, i == 2048});
            step();
        end
        chk("t3_done", {15'd0, done2}, 16'd1);
        chk("t3_fin_valid", {15'd0, av2}, 16'd0);
        step();

        // Empty command: straight to FIN.
        issue(4'd1, 13'd0);
        chk("t4_valid", {15'd0, av1}, 16'd0);
        chk("t4_done", {15'd0, done1}, 16'd1);
        chk("t4_ready_low", {15'd0, rdy1}, 16'd0);
        step();
        chk("t4_valid_idle", {15'd0, av1}, 16'd0);
        chk("t4_done_idle", {15'd0, done1}, 16'd0);
        chk("t4_ready_again", {15'd0, rdy1}, 16'd1);

        // Abort with the third handshake; a command presented during RUN is ignored.
        issue(4'd0, 13'd10);
        cmd_valid = 1'b1; cmd_index = 4'd3; cmd_len = 13'd1;
        chk("t5_addr0", {2'd0, addr1}, 16'h0000);
        chk("t5_ready_run", {15'd0, rdy1}, 16'd0);
        step();
        chk("t5_addr1", {2'd0, addr1}, 16'h0001);
        cmd_valid = 1'b0;
        step();
        chk("t5_addr2", {2'd0, addr1}, 16'h0002);
        chk("t5_last_low", {15'd0, al1}, 16'd0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t5_aborted", {15'd0, ab1}, 16'd1);
        chk("t5_no_done", {15'd0, done1}, 16'd0);
        chk("t5_fin_valid", {15'd0, av1}, 16'd0);
        chk("t5_addr_after", {2'd0, addr1}, 16'h0003);
        step();
        chk("t5_idle_aborted", {15'd0, ab1}, 16'd0);
        chk("t5_idle_done", {15'd0, done1}, 16'd0);
        chk("t5_idle_busy", {15'd0, busy1}, 16'd0);

        // Abort in IDLE is ignored.
        abort = 1'b1;
        step();
        chk("t5_idle_abort_busy", {15'd0, busy1}, 16'd0);
        chk("t5_idle_abort_pulse", {15'd0, ab1}, 16'd0);
        abort = 1'b0;

        // Abort on the final beat yields done, not aborted.
        issue(4'd0, 13'd2);
        chk("t5b_addr0", {2'd0, addr1}, 16'h0000);
        step();
        chk("t5b_last", {15'd0, al1}, 16'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t5b_done", {15'd0, done1}, 16'd1);
        chk("t5b_no_aborted", {15'd0, ab1}, 16'd0);
        step();

        // Reset mid-burst with five beats remaining.
        issue(4'd0, 13'd10);
        for (int i = 0; i < 5; i++) step();
        chk("t6_addr_mid", {2'd0, addr1}, 16'h0005);
        rst = 1'b1;
        step();
        chk("t6_valid", {15'd0, av1}, 16'd0);
        chk("t6_busy", {15'd0, busy1}, 16'd0);
        chk("t6_addr", {2'd0, addr1}, 16'h0000);
        chk("t6_done", {15'd0, done1}, 16'd0);
        chk("t6_aborted", {15'd0, ab1}, 16'd0);
        rst = 1'b0;
        step();
        chk("t6_post_done", {15'd0, done1}, 16'd0);
        chk("t6_post_aborted", {15'd0, ab1}, 16'd0);
        issue(4'd3, 13'd1);
        chk("t6_new_addr", {2'd0, addr1}, 16'h3000);
        chk("t6_new_valid", {15'd0, av1}, 16'd1);
        chk("t6_new_last", {15'd0, al1}, 16'd1);
        step();
        chk("t6_new_done", {15'd0, done1}, 16'd1);
        step();
        chk("t6_new_idle", {15'd0, busy1}, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
